pipe_stage_reg: RTL

//   Generic pipeline stage register for the processor pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: datapath and control bundles with a valid/ready
// handshake, flush to bubble, optional 2-entry skid buffer and a saturating
// stall counter.
//
// state | meaning
// EMPTY | no entry held; out_valid=0, out_ctrl forced to 0
// FULL  | main register holds one entry
// SKIDF | main and skid registers both hold an entry (SKID=1 only); in_ready=0
module pipe_stage_reg #(
    parameter int DATA_W = 97,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              ready_q;
    logic              accept;
    logic              consume;
    logic              load_main;
    logic              load_skid;
    logic              move_skid;

    // ready_q resets to 1 so in_ready rises on the first cycle after reset;
    // masking with reset keeps in_ready low while reset is held.
    assign in_ready  = ~reset & ((SKID != 0) ? ready_q : (out_ready | ~out_valid));
    assign out_valid = (state != EMPTY);
    // An entry offered during a flush cycle is dropped even if in_ready reads 1.
    assign accept    = in_valid & in_ready & ~flush;
    assign consume   = out_valid & out_ready;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    // Next-state and register-load decisions for the handshake.
    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx  = FULL;
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (accept && consume) begin
                    load_main = 1'b1;
                end else if (accept && (SKID != 0)) begin
                    state_nx  = SKIDF;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_nx = EMPTY;
                end
            end
            SKIDF: begin
                if (consume) begin
                    state_nx  = FULL;
                    move_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // State, entry registers and registered ready; reset beats flush beats handshake.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != SKIDF);
            if (load_main) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (move_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // Saturating count of cycles where the downstream stage holds off a valid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
